// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmitter state encodings, frame geometry and command codes.
// Used by the host transmitter, the line synchroniser and the keyboard receiver.
`timescale 1ns/1ps
package ps2_pkg;

    typedef enum logic [2:0] {
        PS2TX_IDLE      = 3'd0,
        PS2TX_INHIBIT   = 3'd1,
        PS2TX_REQ       = 3'd2,
        PS2TX_SEND      = 3'd3,
        PS2TX_ACK       = 3'd4,
        PS2TX_WAIT_IDLE = 3'd5,
        PS2TX_FAIL      = 3'd6
    } ps2tx_state_t;

    // Debug view of the transmitter for checkers and waveforms.
    typedef struct packed {
        ps2tx_state_t state;
        logic [3:0]   edge_cnt;
        logic         clk_fall;
        logic         data_fall;
    } ps2tx_dbg_t;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_LEN = 11;
    // Falling edge on which the device drives its ACK bit.
    localparam int PS2_ACK_EDGE  = 11;
    // Falling edge that presents the stop bit.
    localparam int PS2_STOP_EDGE = PS2_ACK_EDGE - 1;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

    // Bits shifted out after the start bit, LSB first: data, odd parity, stop.
    function automatic logic [9:0] ps2_tx_frame(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchroniser and falling-edge detector for the raw PS2_CLK / PS2_DATA lines.
// Edge flags assert one cycle after the synchronised level changes; SYNC_STAGES must be >= 2.
`timescale 1ns/1ps
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall,
    output logic data_fall
);

    logic [SYNC_STAGES-1:0] clk_ff;
    logic [SYNC_STAGES-1:0] data_ff;
    logic                   clk_prev;
    logic                   data_prev;

    // Idle PS/2 lines are pulled high, so the chain resets to 1 to avoid a spurious edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_ff    <= '1;
            data_ff   <= '1;
            clk_prev  <= 1'b1;
            data_prev <= 1'b1;
            clk_fall  <= 1'b0;
            data_fall <= 1'b0;
        end else begin
            clk_ff    <= {clk_ff[SYNC_STAGES-2:0], ps2_clk};
            data_ff   <= {data_ff[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_ff[SYNC_STAGES-1];
            data_prev <= data_ff[SYNC_STAGES-1];
            clk_fall  <= clk_prev & ~clk_ff[SYNC_STAGES-1];
            data_fall <= data_prev & ~data_ff[SYNC_STAGES-1];
        end
    end

    assign clk_sync  = clk_ff[SYNC_STAGES-1];
    assign data_sync = data_ff[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift 10 bits on device clock, check ACK.
// Optional PS2_TX_RETRY_EN: the first failure silently retries the same byte once.
`timescale 1ns/1ps
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       send,
    output logic       ready,
    output logic       tx_active,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_low,
    output logic       ps2_data_low,
    output ps2tx_dbg_t dbg
);

    logic clk_sync;
    logic data_sync;
    logic clk_fall;
    logic data_fall;

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .clk_fall  (clk_fall),
        .data_fall (data_fall)
    );

    ps2tx_state_t state_q, state_n;
    logic [31:0]  cnt_q, cnt_n;
    logic [3:0]   edge_q, edge_n;
    logic [9:0]   shreg_q, shreg_n;
    logic         drive_q, drive_n;
    logic         watchdog_hit;
`ifdef PS2_TX_RETRY_EN
    logic [7:0]   byte_q, byte_n;
    logic         retry_q, retry_n;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PS2TX_IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            shreg_q <= '1;
            drive_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            byte_q  <= '0;
            retry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            edge_q  <= edge_n;
            shreg_q <= shreg_n;
            drive_q <= drive_n;
`ifdef PS2_TX_RETRY_EN
            byte_q  <= byte_n;
            retry_q <= retry_n;
`endif
        end
    end

    assign watchdog_hit = (cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q + 32'd1;
        edge_n  = edge_q;
        shreg_n = shreg_q;
        drive_n = drive_q;
        done    = 1'b0;
        error   = 1'b0;
`ifdef PS2_TX_RETRY_EN
        byte_n  = byte_q;
        retry_n = retry_q;
`endif
        case (state_q)
            PS2TX_IDLE: begin
                cnt_n   = '0;
                drive_n = 1'b0;
`ifdef PS2_TX_RETRY_EN
                retry_n = 1'b0;
                if (send) byte_n = tx_data;
`endif
                if (send) begin
                    shreg_n = ps2_tx_frame(tx_data);
                    edge_n  = '0;
                    state_n = PS2TX_INHIBIT;
                end
            end
            PS2TX_INHIBIT: begin
                if (cnt_q == 32'(INHIBIT_CYCLES - 1)) begin
                    drive_n = 1'b1;            // start bit goes out with the request
                    state_n = PS2TX_REQ;
                end
            end
            PS2TX_REQ, PS2TX_SEND: begin
                if (clk_fall) begin
                    cnt_n   = '0;
                    drive_n = ~shreg_q[0];
                    shreg_n = {1'b1, shreg_q[9:1]};
                    edge_n  = edge_q + 4'd1;
                    state_n = (edge_q == 4'(PS2_STOP_EDGE - 1)) ? PS2TX_ACK : PS2TX_SEND;
                end else if (watchdog_hit) begin
                    state_n = PS2TX_FAIL;
                end
            end
            PS2TX_ACK: begin
                if (clk_fall) begin
                    cnt_n   = '0;
                    edge_n  = edge_q + 4'd1;
                    state_n = data_sync ? PS2TX_FAIL : PS2TX_WAIT_IDLE;
                end else if (watchdog_hit) begin
                    state_n = PS2TX_FAIL;
                end
            end
            PS2TX_WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done    = 1'b1;
                    state_n = PS2TX_IDLE;
                end else if (clk_fall) begin
                    cnt_n = '0;
                end else if (watchdog_hit) begin
                    state_n = PS2TX_FAIL;
                end
            end
            PS2TX_FAIL: begin
                drive_n = 1'b0;
`ifdef PS2_TX_RETRY_EN
                if (!retry_q) begin
                    retry_n = 1'b1;
                    shreg_n = ps2_tx_frame(byte_q);
                    edge_n  = '0;
                    state_n = PS2TX_INHIBIT;
                end else begin
                    error   = 1'b1;
                    state_n = PS2TX_IDLE;
                end
`else
                error   = 1'b1;
                state_n = PS2TX_IDLE;
`endif
            end
            default: begin
                state_n = PS2TX_IDLE;
            end
        endcase
        // The watchdog and inhibit timer restart on every state entry.
        if (state_n != state_q) cnt_n = '0;
    end

    assign ready        = (state_q == PS2TX_IDLE);
    assign tx_active    = ~ready;
    assign ps2_clk_low  = (state_q == PS2TX_INHIBIT);
    // Data is only ever driven while the host owns the frame bits.
    assign ps2_data_low = drive_q & ((state_q == PS2TX_REQ) || (state_q == PS2TX_SEND));

    assign dbg.state     = state_q;
    assign dbg.edge_cnt  = edge_q;
    assign dbg.clk_fall  = clk_fall;
    assign dbg.data_fall = data_fall;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain line model and a keyboard-side device model.
// Frame bit vectors are {stop, parity, data[7:0], start} as seen by the device.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 6000;
    localparam int TMO  = 3000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       send = 1'b0;
    logic       ready, tx_active, done, error;
    logic       ps2_clk_low, ps2_data_low;
    ps2tx_dbg_t dbg;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic ps2_clk_line, ps2_data_line;
    assign ps2_clk_line  = ~(ps2_clk_low | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_low | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_data      (tx_data),
        .send         (send),
        .ready        (ready),
        .tx_active    (tx_active),
        .done         (done),
        .error        (error),
        .ps2_clk      (ps2_clk_line),
        .ps2_data     (ps2_data_line),
        .ps2_clk_low  (ps2_clk_low),
        .ps2_data_low (ps2_data_low),
        .dbg          (dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line monitor: inhibit run lengths and pulse counts.
    int run_len = 0;
    int last_inh = 0;
    int n_inh = 0;
    int n_done = 0;
    int n_err = 0;
    int n_both = 0;
    always @(negedge clk) begin
        if (ps2_clk_low) run_len <= run_len + 1;
        else if (run_len != 0) begin
            last_inh <= run_len;
            n_inh    <= n_inh + 1;
            run_len  <= 0;
        end
        if (done)          n_done <= n_done + 1;
        if (error)         n_err  <= n_err + 1;
        if (done && error) n_both <= n_both + 1;
    end

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        tx_data = b;
        send    = 1'b1;
        @(negedge clk);
        send    = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < INH + 500; i++) begin
            @(negedge clk);
            if (ps2_clk_line === 1'b1 && ps2_data_line === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_clk_low(input logic v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < INH + TMO + 500; i++) begin
            @(negedge clk);
            if (ps2_clk_low === v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Device side of one host-to-device frame; samples each bit late in the clock-low phase.
    task automatic dev_frame(input bit do_ack, output logic [10:0] bits, output bit ok);
        bits = '1;
        wait_req(ok);
        if (!ok) return;
        bits[0] = ps2_data_line;
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            bits[k] = ps2_data_line;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        dev_data_low = do_ack;
        repeat (HALF / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] b, input logic [10:0] exp_bits, input string tag);
        logic [10:0] bits;
        bit          ok;
        int          i0, d0, e0;
        i0 = n_inh; d0 = n_done; e0 = n_err;
        send_cmd(b);
        dev_frame(1'b1, bits, ok);
        check({tag, "_req"}, 32'(ok), 32'd1);
        check({tag, "_bits"}, 32'(bits), 32'(exp_bits));
        repeat (20) @(negedge clk);
        check({tag, "_done"}, 32'(n_done - d0), 32'd1);
        check({tag, "_err"}, 32'(n_err - e0), 32'd0);
        check({tag, "_inh_cnt"}, 32'(n_inh - i0), 32'd1);
        check({tag, "_inh_len"}, 32'(last_inh), 32'(INH));
        check({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [10:0] bits;
        bit          ok, ok2;
        int          i0, d0, e0, tmo_n;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_active", 32'(tx_active), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_clk_low", 32'(ps2_clk_low), 32'd0);
        check("rst_data_low", 32'(ps2_data_low), 32'd0);
        check("rst_state", 32'(dbg.state), 32'(PS2TX_IDLE));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 0xED: 6 ones -> parity 1
        run_frame(PS2_CMD_SET_LED, 11'b1_1_11101101_0, "ed");
        // 0x01: 1 one -> parity 0
        run_frame(8'h01, 11'b1_0_00000001_0, "x01");
        // 0x00: no ones -> parity 1
        run_frame(8'h00, 11'b1_1_00000000_0, "x00");

        // Send request with 0x55 mid-frame is ignored; 0xF4 (5 ones, parity 0) completes
        i0 = n_inh; d0 = n_done;
        send_cmd(PS2_CMD_ENABLE);
        fork
            dev_frame(1'b1, bits, ok);
            begin
                ok2 = 1'b0;
                for (int i = 0; i < INH + 1000; i++) begin
                    @(negedge clk);
                    if (dbg.state == PS2TX_SEND && dbg.edge_cnt == 4'd3) begin
                        ok2 = 1'b1;
                        break;
                    end
                end
                check("ign_reach_send", 32'(ok2), 32'd1);
                check("ign_ready", 32'(ready), 32'd0);
                check("ign_active", 32'(tx_active), 32'd1);
                tx_data = 8'h55;
                send    = 1'b1;
                @(negedge clk);
                send    = 1'b0;
            end
        join
        check("ign_bits", 32'(bits), 32'(11'b1_0_11110100_0));
        repeat (200) @(negedge clk);
        check("ign_done", 32'(n_done - d0), 32'd1);
        check("ign_no_requeue", 32'(n_inh - i0), 32'd1);
        check("ign_ready_after", 32'(ready), 32'd1);

        // Device never clocks: watchdog fires TMO cycles after the request
        e0 = n_err; d0 = n_done;
        send_cmd(PS2_CMD_RESET);
        wait_clk_low(1'b1, ok);
        wait_clk_low(1'b0, ok2);
`ifdef PS2_TX_RETRY_EN
        wait_clk_low(1'b1, ok);
        wait_clk_low(1'b0, ok2);
`endif
        check("tmo_req_seen", 32'(ok & ok2), 32'd1);
        tmo_n = 0;
        for (int i = 0; i < TMO + 100; i++) begin
            @(negedge clk);
            tmo_n++;
            if (error) break;
        end
        check("tmo_cycles", 32'(tmo_n), 32'(TMO));
        check("tmo_clk_rel", 32'(ps2_clk_low), 32'd0);
        check("tmo_data_rel", 32'(ps2_data_low), 32'd0);
        @(negedge clk);
        check("tmo_ready", 32'(ready), 32'd1);
        check("tmo_err_cnt", 32'(n_err - e0), 32'd1);
        check("tmo_no_done", 32'(n_done - d0), 32'd0);

        // Device omits the ACK
        i0 = n_inh; d0 = n_done; e0 = n_err;
        send_cmd(PS2_CMD_ENABLE);
        dev_frame(1'b0, bits, ok);
        check("nack_req", 32'(ok), 32'd1);
`ifdef PS2_TX_RETRY_EN
        check("nack_retry_err", 32'(n_err - e0), 32'd0);
        dev_frame(1'b0, bits, ok);
        check("nack_retry_req", 32'(ok), 32'd1);
`endif
        repeat (20) @(negedge clk);
        check("nack_err", 32'(n_err - e0), 32'd1);
        check("nack_done", 32'(n_done - d0), 32'd0);
`ifdef PS2_TX_RETRY_EN
        check("nack_inh_cnt", 32'(n_inh - i0), 32'd2);
`else
        check("nack_inh_cnt", 32'(n_inh - i0), 32'd1);
`endif
        check("nack_ready", 32'(ready), 32'd1);

        // Reset during edge 5 of 0xED (bit4 = 0, so data is being driven low)
        d0 = n_done; e0 = n_err;
        send_cmd(PS2_CMD_SET_LED);
        wait_req(ok);
        check("rstmid_req", 32'(ok), 32'd1);
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        dev_clk_low = 1'b1;
        repeat (HALF / 2) @(negedge clk);
        check("rstmid_pre_data_low", 32'(ps2_data_low), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_clk_rel", 32'(ps2_clk_low), 32'd0);
        check("rstmid_data_rel", 32'(ps2_data_low), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_error", 32'(error), 32'd0);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rstmid_ready", 32'(ready), 32'd1);
        check("rstmid_no_pulse", 32'((n_done - d0) + (n_err - e0)), 32'd0);

        check("never_both", 32'(n_both), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
